// File: rtl/miner_pkg.sv
// Shared definitions for the nonce scheduler and the SHA pipelines it feeds.
package miner_pkg;

  localparam int NONCE_W = 32;

  // Latency constants shared with the SHA pipelines: first pass, second pass, full double hash.
  localparam int PIPE_LAT_SHA_FIRST  = 130;
  localparam int PIPE_LAT_SHA_SECOND = 123;
  localparam int PIPE_LAT_DEFAULT    = 253;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Population count of up to eight lane flags.
  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < 8; i++) begin
      c = c + 4'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/nonce_scheduler_if.sv
// Golden-nonce read port: valid/ready stream of found nonces.
interface nonce_scheduler_if;
  import miner_pkg::*;

  logic [NONCE_W-1:0] gold_data;
  logic               gold_valid;
  logic               gold_ready;

  modport master (output gold_data, output gold_valid, input gold_ready);
  modport slave  (input gold_data, input gold_valid, output gold_ready);
endinterface

// File: rtl/gold_fifo.sv
// Small FIFO holding golden nonces until the host reads them.
module gold_fifo #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push_valid,
  input  logic [31:0] push_data,
  output logic        full,
  output logic [31:0] pop_data,
  output logic        pop_valid,
  input  logic        pop_ready
);
  localparam int AW = $clog2(DEPTH);

  logic [31:0] mem_reg [DEPTH];
  logic [AW:0] wr_ptr_reg, rd_ptr_reg;
  logic        empty, pop, push_ok;

  assign empty     = (wr_ptr_reg == rd_ptr_reg);
  assign full      = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                     (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign pop_valid = !empty;
  assign pop       = pop_valid && pop_ready;
  // A pop in the same cycle frees the slot, so a push on a full FIFO still lands.
  assign push_ok   = push_valid && (!full || pop);
  assign pop_data  = empty ? 32'd0 : mem_reg[rd_ptr_reg[AW-1:0]];

  // Storage write; contents need no reset because the pointers qualify them.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_reg[wr_ptr_reg[AW-1:0]] <= push_data;
    end
  end

  // Read/write pointer advance.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)     rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end
endmodule

// File: rtl/nonce_scheduler.sv
// Issues a nonce range across parallel hash lanes and collects golden nonces
// whose hash2 word equals the target.
module nonce_scheduler
  import miner_pkg::*;
#(
  parameter int NUM_CORES  = 2,
  parameter int PIPE_LAT   = PIPE_LAT_DEFAULT,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   abort,
  input  logic [NONCE_W-1:0]     nonce_start,
  input  logic [NONCE_W-1:0]     nonce_end,
  input  logic [NONCE_W-1:0]     target,
  output logic [32*NUM_CORES-1:0] nonce_out,
  output logic [NUM_CORES-1:0]   nonce_vld,
  input  logic [32*NUM_CORES-1:0] hash2_in,
  nonce_scheduler_if.master      gold,
  output logic                   busy,
  output logic                   done,
  output logic [32:0]            checked,
  output logic [7:0]             drop_cnt
);
  state_t state_reg, state_next;

  logic [31:0] base_reg, target_reg, cmp_off_reg, match_base_reg;
  logic [32:0] n_reg, issue_off_reg, checked_reg;
  logic [7:0]  drop_reg;
  logic [NUM_CORES-1:0] vld_dly_reg [PIPE_LAT];
  logic [NUM_CORES-1:0] match_reg, lane_hit, dly_last;

  logic        start_ok, last_issue, push_valid, fifo_full, fifo_pop;
  logic [31:0] push_data;
  logic [2:0]  low_idx;
  logic [3:0]  pc_match, pc_last;
  logic [4:0]  drop_inc;
  logic [8:0]  drop_sum;

  assign start_ok   = start && !abort && (state_reg == ST_IDLE || state_reg == ST_DONE);
  assign last_issue = ({1'b0, issue_off_reg} + 34'(NUM_CORES)) >= {1'b0, n_reg};
  assign dly_last   = vld_dly_reg[PIPE_LAT-1];

  // Per-lane issue and compare; the compare side rebuilds nonces from its own base.
  for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_lane
    assign nonce_vld[gi] = (state_reg == ST_RUN) && ((issue_off_reg + 33'(gi)) < n_reg);
    assign nonce_out[gi*32 +: 32] = (state_reg == ST_RUN) ?
                                    (base_reg + issue_off_reg[31:0] + 32'(gi)) : 32'd0;
    assign lane_hit[gi] = dly_last[gi] && (hash2_in[gi*32 +: 32] == target_reg);
  end

  // Scan FSM next state; abort overrides everything.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (start_ok) state_next = ST_RUN;
      ST_RUN:   if (last_issue) state_next = ST_DRAIN;
      ST_DRAIN: if (checked_reg == n_reg && match_reg == '0) state_next = ST_DONE;
      ST_DONE:  if (start_ok) state_next = ST_RUN;
      default:  state_next = ST_IDLE;
    endcase
    if (abort) state_next = ST_IDLE;
  end

  // Push arbitration: lowest matching lane wins, the rest and full-FIFO pushes count as drops.
  always_comb begin
    low_idx = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (match_reg[i]) low_idx = 3'(i);
    end
    pc_match   = popcount8(8'(match_reg));
    pc_last    = popcount8(8'(dly_last));
    push_valid = (match_reg != '0) && !abort;
    push_data  = match_base_reg + 32'(low_idx);
    drop_inc   = '0;
    if (push_valid) begin
      drop_inc = 5'(pc_match) - 5'd1 + ((fifo_full && !fifo_pop) ? 5'd1 : 5'd0);
    end
    drop_sum = 9'(drop_reg) + 9'(drop_inc);
  end

  // State, scan parameters, issue/compare counters and status counts.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg     <= ST_IDLE;
      base_reg      <= '0;
      target_reg    <= '0;
      n_reg         <= '0;
      issue_off_reg <= '0;
      cmp_off_reg   <= '0;
      checked_reg   <= '0;
      drop_reg      <= '0;
    end else begin
      state_reg <= state_next;
      if (start_ok) begin
        base_reg      <= nonce_start;
        target_reg    <= target;
        n_reg         <= {1'b0, nonce_end - nonce_start} + 33'd1;
        issue_off_reg <= '0;
        cmp_off_reg   <= '0;
        checked_reg   <= '0;
        drop_reg      <= '0;
      end else begin
        if (state_reg == ST_RUN) issue_off_reg <= issue_off_reg + 33'(NUM_CORES);
        if (dly_last != '0) begin
          cmp_off_reg <= cmp_off_reg + 32'(NUM_CORES);
          checked_reg <= checked_reg + 33'(pc_last);
        end
        drop_reg <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
      end
    end
  end

  // Valid-mask delay matching the hash pipeline, plus the registered compare.
  always_ff @(posedge clk) begin
    if (!reset || abort || start_ok) begin
      for (int s = 0; s < PIPE_LAT; s++) vld_dly_reg[s] <= '0;
      match_reg      <= '0;
      match_base_reg <= '0;
    end else begin
      vld_dly_reg[0] <= nonce_vld;
      for (int s = 1; s < PIPE_LAT; s++) vld_dly_reg[s] <= vld_dly_reg[s-1];
      match_reg      <= lane_hit;
      match_base_reg <= base_reg + cmp_off_reg;
    end
  end

  assign fifo_pop = gold.gold_valid && gold.gold_ready;

  gold_fifo #(.DEPTH(FIFO_DEPTH)) u_gold_fifo (
    .clk        (clk),
    .reset      (reset),
    .push_valid (push_valid),
    .push_data  (push_data),
    .full       (fifo_full),
    .pop_data   (gold.gold_data),
    .pop_valid  (gold.gold_valid),
    .pop_ready  (gold.gold_ready)
  );

  assign busy     = (state_reg == ST_RUN) || (state_reg == ST_DRAIN);
  assign done     = (state_reg == ST_DONE);
  assign checked  = checked_reg;
  assign drop_cnt = drop_reg;
endmodule

// File: doc/nonce_scheduler.md
NONCE_SCHEDULER -- requirements
Module: nonce_scheduler

Interface
REQ-001 Parameter NUM_CORES, default 2, number of hash lanes (1..8) fed in parallel.
REQ-002 Parameter PIPE_LAT, default 253, cycles from nonce issue to the matching hash2 word at hash2_in (>= 2).
REQ-003 Parameter FIFO_DEPTH, default 4, golden-nonce FIFO entries (power of 2, 2..16).
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-low reset.
REQ-006 start  in  1  one-cycle pulse; begins a scan of [nonce_start, nonce_end]; honoured only in IDLE or DONE.
REQ-007 abort  in  1  one-cycle pulse; ends any scan and returns to IDLE.
REQ-008 nonce_start, nonce_end  in  32 each  inclusive scan range, sampled on accepted start.
REQ-009 target  in  32  golden compare word, sampled on accepted start.
REQ-010 nonce_out  out  32*NUM_CORES  lane k carries the nonce issued to core k this cycle.
REQ-011 nonce_vld  out  NUM_CORES  per-lane issue qualifier.
REQ-012 hash2_in  in  32*NUM_CORES  lane k hash2 word from core k.
REQ-013 gold_data  out  32; gold_valid  out  1; gold_ready  in  1  golden-nonce FIFO read port, valid/ready.
REQ-014 busy  out  1; done  out  1  scan status.
REQ-015 checked  out  33  count of nonces compared in current scan; drop_cnt  out  8  lost golden nonces, saturating.

Function
REQ-016 FSM states IDLE, RUN, DRAIN, DONE; IDLE->RUN on start; RUN->DRAIN after last issue cycle; DRAIN->DONE after last compare cycle; DONE->RUN on start; any state->IDLE on abort.
REQ-017 Scan length N = (nonce_end - nonce_start mod 2^32) + 1, held in 33 bits; start=0, end=FFFFFFFF gives N=2^32; start>end wraps through FFFFFFFF.
REQ-018 In RUN, cycle i drives lane k with nonce_start + i*NUM_CORES + k (mod 2^32); nonce_vld[k]=1 only if i*NUM_CORES+k < N; final cycle may be partial.
REQ-019 Issue occupies ceil(N/NUM_CORES) cycles, first issue the cycle after start is accepted.
REQ-020 Compare side uses its own base counter, not per-nonce delay lines: lane k of hash2_in at cycle t belongs to the nonce issued at cycle t-PIPE_LAT, valid mask delayed identically.
REQ-021 A lane matches when its delayed valid is set and hash2_in lane equals target; compare is registered, so FIFO push occurs one cycle after hash2_in sampling.
REQ-022 At most one push per cycle: lowest-index matching lane is pushed; every other matching lane that cycle increments drop_cnt.
REQ-023 Push while FIFO full is discarded and increments drop_cnt; simultaneous push and pop on full FIFO succeeds with no drop.
REQ-024 gold_valid=1 whenever FIFO non-empty; entry removed on gold_valid and gold_ready; FIFO order is push order.
REQ-025 checked increments by popcount of delayed valid lanes per compare cycle; equals N in DONE.
REQ-026 busy=1 in RUN and DRAIN; done=1 only in DONE; start in RUN or DRAIN is ignored.
REQ-027 abort clears nonce_vld the same edge, discards in-flight compares, preserves FIFO contents and drop_cnt; abort and start in the same cycle: abort wins.
REQ-028 Accepted start clears checked and drop_cnt; FIFO contents survive.

Reset
REQ-029 While reset=0 at a rising edge: state IDLE, FIFO empty, gold_valid=0, gold_data=0, nonce_vld=0, nonce_out=0, busy=0, done=0, checked=0, drop_cnt=0.
REQ-030 Reset mid-scan has the same effect as REQ-029; first start is accepted the cycle after reset returns to 1.

Structure
REQ-031 Shared package miner_pkg holds FSM state enumeration, NONCE_W=32, and default PIPE_LAT constants (130, 123, 253) shared with the SHA pipelines.
REQ-032 Golden FIFO is sub-module gold_fifo (parameter DEPTH, width 32, valid/ready out, full flag); remaining logic flat.

Verification
REQ-033 NUM_CORES=2, PIPE_LAT=4, range 0x10..0x14, target 0xA41F32E7, model returns target for nonce 0x13 -> gold_data 0x13 once, checked=5, final issue cycle only lane0 valid (0x14), done after drain.
REQ-034 NUM_CORES=4, lanes 1 and 3 match in same cycle (nonces 0x101, 0x103) -> FIFO holds 0x101, drop_cnt=1.
REQ-035 FIFO_DEPTH=2, gold_ready=0, three matches -> two entries kept in order, drop_cnt=1; then ready=1 drains both.
REQ-036 range start=0xFFFFFFFE, end=0x00000001, NUM_CORES=1 -> issues FFFFFFFE, FFFFFFFF, 0, 1; checked=4.
REQ-037 abort during RUN with one match in flight -> nonce_vld=0 next cycle, match not pushed, state IDLE, earlier FIFO entry still readable.
REQ-038 reset=0 for one cycle during DRAIN -> all outputs at REQ-029 values, FIFO empty, new start scans correctly.
